data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised, byte-addressable data memory with a req/ready handshake. It is the data-memory stage for the multi-cycle and pipelined cores. Compared with the fixed 64-word word-only memory, it adds byte, halfword and word accesses, sign and zero extension on loads, misalignment detection, configurable access latency and a hardware clear sweep after reset. The core's load/store unit drives it and stalls on ready.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, minimum 4
LATENCY, 0, extra wait cycles per access; range 0..7

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
req  input  1  access request; sampled only in IDLE
we  input  1  1 = store, 0 = load
size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned)
unsigned_ld  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
Addr  input  32  byte address
WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
RD  output  32  load result, registered, extended to 32 bits
ready  output  1  one-cycle completion pulse
misalign  output  1  error flag, valid only while ready=1
init_done  output  1  high once the clear sweep has finished

Behaviour:
- Async reset (rst_n=0):
  - State goes to INIT; ready=0, misalign=0, RD=0, init_done=0; internal counters cleared.
  - The array itself is not reset.
- INIT state:
  - After rst_n rises, one word is zeroed per clock, indices 0..DEPTH-1: DEPTH cycles in total.
  - init_done is set on the edge that writes index DEPTH-1; state then goes to IDLE.
  - req during INIT is ignored, not queued.
- Word index = Addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Alignment rules:
  - Half: Addr[0] must be 0.
  - Word: Addr[1:0] must be 00.
  - size=11: always misaligned.
- IDLE state:
  - req=1 at edge E0 captures Addr, WD, we, size and unsigned_ld.
  - State goes to BUSY with wait counter = LATENCY.
- BUSY state:
  - On each edge, if counter≠0, decrement.
  - If counter=0, perform the access, set ready=1 for one cycle and return to IDLE.
  - ready is therefore visible after edge E(LATENCY+1).
- Access:
  - Store byte: writes WD[7:0] into lane Addr[1:0] only.
  - Store half: writes WD[15:0] into lanes {Addr[1],0} and {Addr[1],1} only.
  - Store word: writes all lanes.
  - Load: RD is loaded with the selected lane(s), extended per unsigned_ld; word loads ignore unsigned_ld.
- Stores leave RD unchanged.
- RD holds its value until the next load completes.
- Misaligned access: no array write and RD unchanged; ready=1 and misalign=1 on the same cycle.
- Back-to-back requests: state is IDLE during the ready cycle, so req sampled on the edge ending that cycle is accepted. Peak throughput is one access per LATENCY+2 cycles.
- Read-after-write: a store commits on its completion edge, so any later load returns the new data.
- Inputs are don't-care outside the capture edge. req held high in BUSY has no effect.
- Reset during BUSY aborts the access: no partial write, no ready, INIT sweep restarts.

Test Plan:
- Reset release, DEPTH=64 -> init_done rises exactly 64 cycles after rst_n rises; req issued at cycle 10 gets no ready; a load from 0x0C afterwards returns 0x00000000.
- LATENCY=0: store word 0xDEADBEEF at 0x10, then load word 0x10 -> ready one cycle after each acceptance; RD=0xDEADBEEF, misalign=0.
- Store byte 0x80 at 0x21 over a word holding 0x11223344 -> word becomes 0x11228044; signed byte load at 0x21 gives RD=0xFFFFFF80; unsigned gives 0x00000080; half load at 0x22 (signed) gives 0x00001122.
- Store word at 0x102 and load half at 0x33 -> ready=1, misalign=1, array and RD unchanged; a load word at 0x100 afterwards returns the prior value.
- LATENCY=3: load request accepted at edge E0 -> ready after edge E4; req toggled during BUSY is ignored; a back-to-back request issued on the ready cycle is accepted.
- Wrap: DEPTH=64, store word 0xCAFEF00D at 0x104 -> load at 0x004 returns 0xCAFEF00D.
- Reset mid-op: rst_n pulsed low during BUSY of a store to 0x40 (LATENCY=3) -> no ready; after the INIT sweep, 0x40 reads 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressable data memory with req/ready handshake, sub-word access, configurable latency and post-reset clear sweep.
module data_mem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        ready,
    output logic        misalign,
    output logic        init_done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {INIT, IDLE, BUSY} state_t;
    state_t          state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic [AW-1:0]   init_idx, idx;
    logic [31:0]     mem [DEPTH];
    logic [AW+1:0]   a_q;
    logic [31:0]     wd_q, wlane, word, ld;
    logic [1:0]      size_q;
    logic            we_q, uns_q, init_we, acc, mis;
    logic [3:0]      be;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic            unused_addr;
    assign unused_addr = ^Addr[31:AW+2];
    assign idx   = a_q[AW+1:2];
    assign mis   = size_q == 2'b11 || (size_q == 2'b01 && a_q[0]) || (size_q == 2'b10 && a_q[1:0] != 2'b00);
    assign be    = size_q == 2'b00 ? 4'b0001 << a_q[1:0] : size_q == 2'b01 ? (a_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlane = size_q == 2'b00 ? {4{wd_q[7:0]}} : size_q == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
    assign word  = mem[idx];
    assign lb    = word[{a_q[1:0], 3'b000} +: 8];
    assign lh    = a_q[1] ? word[31:16] : word[15:0];
    assign ld    = size_q == 2'b00 ? {{24{lb[7] & ~uns_q}}, lb} : size_q == 2'b01 ? {{16{lh[15] & ~uns_q}}, lh} : word;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        init_we = 1'b0;
        acc     = 1'b0;
        case (state)
            INIT: begin
                init_we = 1'b1;
                state_n = init_idx == {AW{1'b1}} ? IDLE : INIT;
            end
            IDLE: begin
                state_n = req ? BUSY : IDLE;
                cnt_n   = 3'(LATENCY);
            end
            BUSY: begin
                acc     = cnt == 3'd0;
                cnt_n   = acc ? cnt : cnt - 3'd1;
                state_n = acc ? IDLE : BUSY;
            end
            default: state_n = INIT;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            ready     <= 1'b0;
            misalign  <= 1'b0;
            RD        <= '0;
            a_q       <= '0;
            wd_q      <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ready    <= acc;
            misalign <= acc && mis;
            if (init_we) init_idx <= init_idx + 1'b1;
            if (init_we && init_idx == {AW{1'b1}}) init_done <= 1'b1;
            if (acc && !we_q && !mis) RD <= ld;
            if (state == IDLE && req) begin
                a_q    <= Addr[AW+1:0];
                wd_q   <= WD;
                size_q <= size;
                we_q   <= we;
                uns_q  <= unsigned_ld;
            end
        end
    end
    // Array has no reset; the INIT sweep clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (init_we) mem[init_idx] <= '0;
        else if (acc && we_q && !mis)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector bench for data_mem_ctrl at LATENCY 0 and 3.
module tb_data_mem_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req3 = 1'b0, we = 1'b0, unsigned_ld = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0, wd = '0;
    logic [31:0] rd0, rd3;
    logic        ready0, ready3, mis0, mis3, done0, done3;
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    data_mem_ctrl #(.DEPTH(64), .LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .Addr(addr), .WD(wd), .RD(rd0), .ready(ready0), .misalign(mis0), .init_done(done0)
    );
    data_mem_ctrl #(.DEPTH(64), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .size(size), .unsigned_ld(unsigned_ld),
        .Addr(addr), .WD(wd), .RD(rd3), .ready(ready3), .misalign(mis3), .init_done(done3)
    );
    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        mis;
    } vec_t;
    vec_t v[26];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic m, output int lat);
        @(negedge clk);
        we = w; size = sz; unsigned_ld = u; addr = a; wd = d;
        if (sel) req3 = 1'b1; else req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        lat = 0;
        while (!(sel ? ready3 : ready0) && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        r = sel ? rd3 : rd0;
        m = sel ? mis3 : mis0;
    endtask
    initial begin
        logic [31:0] r;
        logic        m, rdy;
        int          lat, c0, c3;
        v[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0};
        v[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        v[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h11223344, 32'hDEADBEEF, 1'b0};
        v[3]  = '{1'b1, 2'd0, 1'b0, 32'h21,  32'hABCDEF80, 32'hDEADBEEF, 1'b0};
        v[4]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h11228044, 1'b0};
        v[5]  = '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0,        32'hFFFFFF80, 1'b0};
        v[6]  = '{1'b0, 2'd0, 1'b1, 32'h21,  32'h0,        32'h00000080, 1'b0};
        v[7]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'h00001122, 1'b0};
        v[8]  = '{1'b1, 2'd1, 1'b0, 32'h22,  32'h12348001, 32'h00001122, 1'b0};
        v[9]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
        v[10] = '{1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        32'h00008001, 1'b0};
        v[11] = '{1'b0, 2'd0, 1'b0, 32'h20,  32'h0,        32'h00000044, 1'b0};
        v[12] = '{1'b0, 2'd2, 1'b1, 32'h20,  32'h0,        32'h80018044, 1'b0};
        v[13] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h5555AAAA, 32'h80018044, 1'b0};
        v[14] = '{1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFFFFFF, 32'h80018044, 1'b1};
        v[15] = '{1'b0, 2'd1, 1'b0, 32'h33,  32'h0,        32'h80018044, 1'b1};
        v[16] = '{1'b0, 2'd3, 1'b0, 32'h20,  32'h0,        32'h80018044, 1'b1};
        v[17] = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h5555AAAA, 1'b0};
        v[18] = '{1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 32'h5555AAAA, 1'b0};
        v[19] = '{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,        32'hCAFEF00D, 1'b0};
        v[20] = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h000000DE, 1'b0};
        v[21] = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0};
        v[22] = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
        v[23] = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0,        32'h0000BEEF, 1'b1};
        v[24] = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h0000007F, 32'h0000BEEF, 1'b0};
        v[25] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h7FADBEEF, 1'b0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {30'b0, ready0, ready3}, 32'h0);
        chk("rst_misalign", {30'b0, mis0, mis3}, 32'h0);
        chk("rst_init_done", {30'b0, done0, done3}, 32'h0);
        chk("rst_rd", rd0 | rd3, 32'h0);
        rst_n = 1'b1;
        rdy = 1'b0; c0 = 0; c3 = 0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                we = 1'b0; size = 2'd2; addr = 32'h0C; req0 = 1'b1; req3 = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            req0 = 1'b0; req3 = 1'b0;
            if (ready0 | ready3) rdy = 1'b1;
            if (done0 && c0 == 0) c0 = c;
            if (done3 && c3 == 0) c3 = c;
        end
        chk("init_cycles_l0", c0, 64);
        chk("init_cycles_l3", c3, 64);
        chk("init_req_ignored", {31'b0, rdy}, 32'h0);
        access(1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, r, m, lat);
        chk("clr_rd_l0", r, 32'h0);
        chk("clr_lat_l0", lat, 1);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, r, m, lat);
        chk("clr_rd_l3", r, 32'h0);
        chk("clr_lat_l3", lat, 4);
        for (int i = 0; i < 26; i++) begin
            access(1'b0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d, r, m, lat);
            chk($sformatf("vec%0d_rd", i), r, v[i].rd);
            chk($sformatf("vec%0d_mis", i), {31'b0, m}, {31'b0, v[i].mis});
            chk($sformatf("vec%0d_lat", i), lat, 1);
        end
        access(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h01234567, r, m, lat);
        chk("l3_store_lat", lat, 4);
        @(negedge clk);
        we = 1'b0; size = 2'd2; addr = 32'h10; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wd = 32'hFFFFFFFF; req3 = 1'b0;
        chk("busy_e1_ready", {31'b0, ready3}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b1;
        chk("busy_e2_ready", {31'b0, ready3}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        chk("busy_e3_ready", {31'b0, ready3}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b1;
        chk("busy_e4_ready", {31'b0, ready3}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("l3_ready_e4", {31'b0, ready3}, 32'h1);
        chk("l3_rd_e4", rd3, 32'h01234567);
        chk("l3_mis_e4", {31'b0, mis3}, 32'h0);
        we = 1'b1; size = 2'd2; addr = 32'h14; wd = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        chk("ready_pulse", {31'b0, ready3}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", i), {31'b0, ready3}, {31'b0, i == 4});
        end
        chk("b2b_store_rd_kept", rd3, 32'h01234567);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, m, lat);
        chk("busy_req_ignored", r, 32'h0);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r, m, lat);
        chk("b2b_store_data", r, 32'hA5A5A5A5);
        @(negedge clk);
        we = 1'b1; size = 2'd2; addr = 32'h40; wd = 32'hFFFFFFFF; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_rd_cleared", rd3, 32'h0);
        chk("abort_init_done", {31'b0, done3}, 32'h0);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready3) rdy = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 100 && !done3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready3) rdy = 1'b1;
        end
        chk("abort_no_ready", {31'b0, rdy}, 32'h0);
        chk("abort_reinit", {31'b0, done3}, 32'h1);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, r, m, lat);
        chk("abort_no_write", r, 32'h0);
        chk("abort_lat", lat, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
